ahb_bus_arbiter: RTL and testbench



---
 rtl/ahb_pkg.sv | 26 ++
 rtl/ahb_rr_pick.sv | 21 ++
 rtl/ahb_bus_arbiter.sv | 88 ++++++++
 tb/tb_ahb_bus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and burst-length helper.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Undefined-length INCR and SINGLE both report one beat.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        return (hburst inside {HBURST_WRAP4, HBURST_INCR4})   ? 5'd4  :
               (hburst inside {HBURST_WRAP8, HBURST_INCR8})   ? 5'd8  :
               (hburst inside {HBURST_WRAP16, HBURST_INCR16}) ? 5'd16 : 5'd1;
    endfunction
endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick: combinational round-robin picker; scans last+1 .. last, owner last.
module ahb_rr_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    output logic          valid,
    output logic [MW-1:0] winner
);
    always_comb begin
        valid  = 1'b0;
        winner = last;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                valid  = 1'b1;
                winner = MW'((int'(last) + i) % N);
            end
        end
    end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-Lite arbiter with burst lock and address/write-data muxing.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NO_OF_MASTERS = 4,
    parameter int MW            = $clog2(NO_OF_MASTERS)
) (
    input  logic                                HCLK,
    input  logic                                HRESET,
    input  logic [NO_OF_MASTERS-1:0]            HBUSREQ,
    input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0] M_HADDR,
    input  logic [NO_OF_MASTERS*2-1:0]          M_HTRANS,
    input  logic [NO_OF_MASTERS-1:0]            M_HWRITE,
    input  logic [NO_OF_MASTERS*3-1:0]          M_HSIZE,
    input  logic [NO_OF_MASTERS*3-1:0]          M_HBURST,
    input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0] M_HWDATA,
    input  logic                                HREADY,
    input  logic [1:0]                          HRESP,
    output logic [NO_OF_MASTERS-1:0]            HGRANT,
    output logic [MW-1:0]                       HMASTER,
    output logic [MW-1:0]                       HMASTER_D,
    output logic [ADDR_WIDTH-1:0]               HADDR,
    output logic [1:0]                          HTRANS,
    output logic                                HWRITE,
    output logic [2:0]                          HSIZE,
    output logic [2:0]                          HBURST,
    output logic [DATA_WIDTH-1:0]               HWDATA
);
    logic [NO_OF_MASTERS-1:0] r_grant;
    logic [MW-1:0]            r_master;
    logic [MW-1:0]            r_master_d;
    logic [3:0]               r_cnt;
    logic                     r_incr;
    logic [3:0]               w_cnt_n;
    logic                     w_incr_n;
    logic                     w_locked;
    logic                     w_valid;
    logic [MW-1:0]            w_winner;

    ahb_rr_pick #(.N(NO_OF_MASTERS), .MW(MW)) u_pick (
        .req    (HBUSREQ),
        .last   (r_master),
        .valid  (w_valid),
        .winner (w_winner)
    );

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTER_D = r_master_d;
    assign HADDR     = M_HADDR[int'(r_master)*ADDR_WIDTH +: ADDR_WIDTH];
    assign HTRANS    = |r_grant ? M_HTRANS[int'(r_master)*2 +: 2] : HTRANS_IDLE;
    assign HWRITE    = M_HWRITE[r_master];
    assign HSIZE     = M_HSIZE[int'(r_master)*3 +: 3];
    assign HBURST    = M_HBURST[int'(r_master)*3 +: 3];
    assign HWDATA    = M_HWDATA[int'(r_master_d)*DATA_WIDTH +: DATA_WIDTH];

    // Lock state as it will stand after the transfer accepted at this edge.
    assign w_cnt_n  = (HTRANS == HTRANS_NONSEQ) ? 4'(burst_beats(HBURST) - 5'd1) :
                      (HTRANS == HTRANS_SEQ)    ? r_cnt - 4'(r_cnt != 4'd0)       : r_cnt;
    assign w_incr_n = ((HTRANS == HTRANS_NONSEQ) ? (HBURST == HBURST_INCR) : r_incr)
                      & HBUSREQ[r_master] & (HTRANS != HTRANS_IDLE);
    assign w_locked = (w_cnt_n != 4'd0) | w_incr_n;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_grant    <= '0;
            r_master   <= '0;
            r_master_d <= '0;
            r_cnt      <= '0;
            r_incr     <= 1'b0;
        end else if (HREADY) begin
            r_cnt  <= w_cnt_n;
            r_incr <= w_incr_n;
            if (|r_grant)
                r_master_d <= r_master;
            if (!w_locked) begin
                r_grant <= w_valid ? NO_OF_MASTERS'(1) << w_winner : '0;
                if (w_valid)
                    r_master <= w_winner;
            end
        end else if (HRESP == HRESP_ERROR) begin
            r_cnt  <= '0;
            r_incr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed self-checking bench for ahb_bus_arbiter.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   busreq;
    logic [127:0] m_haddr;
    logic [7:0]   m_htrans;
    logic [3:0]   m_hwrite;
    logic [11:0]  m_hsize;
    logic [11:0]  m_hburst;
    logic [127:0] m_hwdata;
    logic         hready;
    logic [1:0]   hresp;
    logic [3:0]   hgrant;
    logic [1:0]   hmaster;
    logic [1:0]   hmaster_d;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hwrite;
    logic [2:0]   hsize;
    logic [2:0]   hburst;
    logic [31:0]  hwdata;
    int           errors = 0;
    int           checks = 0;

    ahb_bus_arbiter dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .HBUSREQ   (busreq),
        .M_HADDR   (m_haddr),
        .M_HTRANS  (m_htrans),
        .M_HWRITE  (m_hwrite),
        .M_HSIZE   (m_hsize),
        .M_HBURST  (m_hburst),
        .M_HWDATA  (m_hwdata),
        .HREADY    (hready),
        .HRESP     (hresp),
        .HGRANT    (hgrant),
        .HMASTER   (hmaster),
        .HMASTER_D (hmaster_d),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HBURST    (hburst),
        .HWDATA    (hwdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic [1:0] t, input logic [2:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        m_htrans[i*2 +: 2]  = t;
        m_hburst[i*3 +: 3]  = b;
        m_haddr[i*32 +: 32] = a;
        m_hwdata[i*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; busreq = '0; hready = 1'b1; hresp = HRESP_OKAY;
        m_haddr = '0; m_htrans = '0; m_hwrite = 4'b0001; m_hsize = 12'h492; m_hburst = '0; m_hwdata = '0;
        set_m(0, HTRANS_IDLE, HBURST_SINGLE, 32'h4, 32'hA5);
        tick(); tick();
        chk("reset_grant", 32'(hgrant), 32'h0);
        chk("reset_master", 32'(hmaster), 32'h0);
        chk("reset_master_d", 32'(hmaster_d), 32'h0);
        chk("reset_htrans", 32'(htrans), 32'h0);
        chk("reset_haddr", haddr, 32'h4);

        // Single handover to M0
        rst = 1'b0; busreq = 4'b0001;
        set_m(0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h4, 32'hA5);
        tick();
        chk("single_grant", 32'(hgrant), 32'h1);
        chk("single_htrans", 32'(htrans), 32'h2);
        chk("single_haddr", haddr, 32'h4);
        chk("single_hwrite", 32'(hwrite), 32'h1);
        tick();
        chk("single_hwdata", hwdata, 32'hA5);
        chk("single_master_d", 32'(hmaster_d), 32'h0);
        busreq = '0;
        set_m(0, HTRANS_IDLE, HBURST_SINGLE, 32'h4, 32'hA5);
        tick();
        chk("idle_grant", 32'(hgrant), 32'h0);
        chk("idle_htrans", 32'(htrans), 32'h0);

        // Round robin, all four requesting SINGLE
        busreq = 4'hF;
        for (int i = 0; i < 4; i++) set_m(i, HTRANS_NONSEQ, HBURST_SINGLE, 32'h1000 + 32'(i*16), 32'hD0 + 32'(i));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("rr_master", 32'(hmaster), 32'(k % 4));
            chk("rr_grant", 32'(hgrant), 32'(1 << (k % 4)));
            chk("rr_htrans", 32'(htrans), 32'h2);
            if (k > 1) begin
                chk("rr_master_d", 32'(hmaster_d), 32'((k - 1) % 4));
                chk("rr_hwdata", hwdata, 32'hD0 + 32'((k - 1) % 4));
            end
        end
        busreq = '0;
        for (int i = 0; i < 4; i++) set_m(i, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 32'h0);
        tick();
        chk("rr_park_grant", 32'(hgrant), 32'h0);
        chk("rr_park_master", 32'(hmaster), 32'h1);

        // Burst lock: M0 INCR4, M1 waits from beat 1
        busreq = 4'b0001;
        set_m(0, HTRANS_NONSEQ, HBURST_INCR4, 32'h100, 32'h11);
        tick();
        chk("bl_grant", 32'(hgrant), 32'h1);
        busreq = 4'b0011;
        set_m(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h200, 32'h22);
        tick();
        chk("bl_hold1", 32'(hmaster), 32'h0);
        set_m(0, HTRANS_SEQ, HBURST_INCR4, 32'h104, 32'h12);
        tick();
        chk("bl_hold2", 32'(hmaster), 32'h0);
        chk("bl_hold2_d", 32'(hmaster_d), 32'h0);
        set_m(0, HTRANS_SEQ, HBURST_INCR4, 32'h108, 32'h13);
        tick();
        chk("bl_hold3", 32'(hgrant), 32'h1);
        set_m(0, HTRANS_SEQ, HBURST_INCR4, 32'h10C, 32'h14);
        busreq = 4'b0010;
        tick();
        chk("bl_handover_grant", 32'(hgrant), 32'h2);
        chk("bl_handover_master", 32'(hmaster), 32'h1);
        chk("bl_handover_master_d", 32'(hmaster_d), 32'h0);
        chk("bl_handover_htrans", 32'(htrans), 32'h2);
        chk("bl_handover_haddr", haddr, 32'h200);
        chk("bl_handover_hwdata", hwdata, 32'h14);
        set_m(0, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 32'h0);
        busreq = '0;
        tick();
        chk("bl_m1_master_d", 32'(hmaster_d), 32'h1);
        chk("bl_park", 32'(hgrant), 32'h0);
        chk("bl_m1_hwdata", hwdata, 32'h22);
        set_m(1, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 32'h0);

        // Wait states during WRAP8 beat 2
        busreq = 4'b0100;
        set_m(2, HTRANS_NONSEQ, HBURST_WRAP8, 32'h300, 32'h30);
        tick();
        chk("ws_grant", 32'(hgrant), 32'h4);
        busreq = 4'b1100;
        set_m(3, HTRANS_NONSEQ, HBURST_SINGLE, 32'h400, 32'h40);
        tick();
        chk("ws_master", 32'(hmaster), 32'h2);
        set_m(2, HTRANS_SEQ, HBURST_WRAP8, 32'h304, 32'h31);
        hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("ws_freeze_grant", 32'(hgrant), 32'h4);
            chk("ws_freeze_master_d", 32'(hmaster_d), 32'h2);
            chk("ws_freeze_htrans", 32'(htrans), 32'h3);
        end
        hready = 1'b1;
        for (int b = 2; b <= 8; b++) begin
            set_m(2, HTRANS_SEQ, HBURST_WRAP8, 32'h300 + 32'(4*(b-1)), 32'h30 + 32'(b-1));
            tick();
            if (b < 8) chk("ws_locked", 32'(hmaster), 32'h2);
            else chk("ws_handover", 32'(hmaster), 32'h3);
        end
        busreq = '0;
        set_m(2, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 32'h0);
        tick();
        chk("ws_end_master_d", 32'(hmaster_d), 32'h3);
        set_m(3, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 32'h0);

        // Error abort during INCR8, M2 waiting
        busreq = 4'b0001;
        set_m(0, HTRANS_NONSEQ, HBURST_INCR8, 32'h500, 32'h50);
        tick();
        chk("er_grant", 32'(hgrant), 32'h1);
        busreq = 4'b0101;
        set_m(2, HTRANS_NONSEQ, HBURST_SINGLE, 32'h600, 32'h60);
        tick();
        set_m(0, HTRANS_SEQ, HBURST_INCR8, 32'h504, 32'h51);
        tick();
        chk("er_locked", 32'(hmaster), 32'h0);
        set_m(0, HTRANS_SEQ, HBURST_INCR8, 32'h508, 32'h52);
        hready = 1'b0; hresp = HRESP_ERROR;
        tick();
        chk("er_wait_master", 32'(hmaster), 32'h0);
        chk("er_wait_grant", 32'(hgrant), 32'h1);
        hready = 1'b1;
        set_m(0, HTRANS_IDLE, HBURST_INCR8, 32'h508, 32'h52);
        tick();
        chk("er_grant_m2", 32'(hgrant), 32'h4);
        chk("er_master", 32'(hmaster), 32'h2);
        chk("er_master_d", 32'(hmaster_d), 32'h0);
        hresp = HRESP_OKAY;

        // Reset during INCR16 beat 5
        busreq = 4'b0110;
        set_m(1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h800, 32'h80);
        set_m(2, HTRANS_NONSEQ, HBURST_INCR16, 32'h700, 32'h70);
        tick();
        chk("rm_hold", 32'(hmaster), 32'h2);
        for (int b = 2; b <= 4; b++) begin
            set_m(2, HTRANS_SEQ, HBURST_INCR16, 32'h700 + 32'(4*(b-1)), 32'h70 + 32'(b-1));
            tick();
            chk("rm_locked", 32'(hmaster), 32'h2);
        end
        set_m(2, HTRANS_SEQ, HBURST_INCR16, 32'h710, 32'h74);
        rst = 1'b1;
        tick();
        chk("rm_grant", 32'(hgrant), 32'h0);
        chk("rm_htrans", 32'(htrans), 32'h0);
        chk("rm_master", 32'(hmaster), 32'h0);
        chk("rm_master_d", 32'(hmaster_d), 32'h0);
        rst = 1'b0;
        busreq = 4'b0100;
        set_m(2, HTRANS_NONSEQ, HBURST_INCR16, 32'h700, 32'h70);
        tick();
        chk("rm_regrant", 32'(hgrant), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
